// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer sitting directly behind the UART RX controller.
// A new byte is detected from the rising edge of the controller's done level,
// stored in a circular FIFO and handed to the consumer through a
// read-enable / valid handshake. A dropped byte sets a sticky overrun flag.
//
// Ports
//   clk            system clock, all logic on its rising edge
//   reset_n        synchronous active-low reset
//   i_Rx_Done      RX controller done level (may stay high many cycles)
//   i_Rx_Byte      received byte, stable while i_Rx_Done is high
//   i_Rd_En        consumer read request
//   i_Clr_Overrun  clears o_Overrun (a simultaneous new overrun wins)
//   o_Rd_Data      byte popped by the previous accepted read
//   o_Rd_Valid     one-cycle pulse qualifying o_Rd_Data
//   o_Empty        FIFO holds no entries
//   o_Full         FIFO holds DEPTH entries
//   o_Count        occupancy, 0..DEPTH
//   o_Overrun      sticky flag, a byte was dropped
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_Rx_Done,
  input  logic [DATA_WIDTH-1:0] i_Rx_Byte,
  input  logic                  i_Rd_En,
  input  logic                  i_Clr_Overrun,
  output logic [DATA_WIDTH-1:0] o_Rd_Data,
  output logic                  o_Rd_Valid,
  output logic                  o_Empty,
  output logic                  o_Full,
  output logic [ADDR_WIDTH:0]   o_Count,
  output logic                  o_Overrun
);

  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  doneDly_q;
  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic                  rdValid_q, rdValid_d;

  logic wrStrobe;
  logic rdAccept;
  logic wrAccept;
  logic overrunSet;

  // The RX controller holds done for many system cycles, so only its
  // low-to-high transition counts as a new byte. A full FIFO still accepts
  // a write when a read frees the head slot in the same cycle.
  assign wrStrobe   = i_Rx_Done & ~doneDly_q;
  assign rdAccept   = i_Rd_En & ~empty_q;
  assign wrAccept   = wrStrobe & (~full_q | rdAccept);
  assign overrunSet = wrStrobe & full_q & ~rdAccept;

  // Next-state logic for pointers, occupancy, flags and the read port.
  // Flags are derived from the next count so they are registered alongside
  // it and never combinationally depend on inputs.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    rdData_d  = rdData_q;
    rdValid_d = 1'b0;

    if (wrAccept) begin
      wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
    end

    if (rdAccept) begin
      rdPtr_d   = rdPtr_q + ADDR_WIDTH'(1);
      rdData_d  = mem_q[rdPtr_q];
      rdValid_d = 1'b1;
    end

    if (wrAccept && !rdAccept) begin
      count_d = count_q + (ADDR_WIDTH+1)'(1);
    end else if (rdAccept && !wrAccept) begin
      count_d = count_q - (ADDR_WIDTH+1)'(1);
    end

    // A new overrun in the same cycle as a clear must not be lost.
    if (overrunSet) begin
      overrun_d = 1'b1;
    end else if (i_Clr_Overrun) begin
      overrun_d = 1'b0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == FullCount);
  end

  // Control state register. The done delay resets high so that a done level
  // already present when reset is released is not mistaken for a new byte.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      doneDly_q <= 1'b1;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      doneDly_q <= i_Rx_Done;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

  // Storage array, deliberately not reset. On a full write-plus-read the
  // write pointer equals the read pointer; the read port above captures the
  // old head before this write replaces it.
  always_ff @(posedge clk) begin
    if (reset_n && wrAccept) begin
      mem_q[wrPtr_q] <= i_Rx_Byte;
    end
  end

  assign o_Rd_Data  = rdData_q;
  assign o_Rd_Valid = rdValid_q;
  assign o_Empty    = empty_q;
  assign o_Full     = full_q;
  assign o_Count    = count_q;
  assign o_Overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. A queue-based model predicts the
// FIFO's visible behaviour each cycle; directed scenarios add hand-computed
// literal expectations.
module tb_uart_rx_fifo;

  localparam int DataWidth = 8;
  localparam int Depth     = 16;
  localparam int AddrWidth = $clog2(Depth);

  logic                 clk;
  logic                 reset_n;
  logic                 i_Rx_Done;
  logic [DataWidth-1:0] i_Rx_Byte;
  logic                 i_Rd_En;
  logic                 i_Clr_Overrun;
  logic [DataWidth-1:0] o_Rd_Data;
  logic                 o_Rd_Valid;
  logic                 o_Empty;
  logic                 o_Full;
  logic [AddrWidth:0]   o_Count;
  logic                 o_Overrun;

  int nChecks = 0;
  int nErrors = 0;

  uart_rx_fifo #(.DATA_WIDTH(DataWidth), .DEPTH(Depth)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_Rx_Done    (i_Rx_Done),
    .i_Rx_Byte    (i_Rx_Byte),
    .i_Rd_En      (i_Rd_En),
    .i_Clr_Overrun(i_Clr_Overrun),
    .o_Rd_Data    (o_Rd_Data),
    .o_Rd_Valid   (o_Rd_Valid),
    .o_Empty      (o_Empty),
    .o_Full       (o_Full),
    .o_Count      (o_Count),
    .o_Overrun    (o_Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared comparison helper, used by the per-cycle compare and directed checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a byte queue plus the few observable flags.
  logic [DataWidth-1:0] modelQ[$];
  logic                 prevDone   = 1'b1;
  logic                 modelOvr   = 1'b0;
  logic                 expValid   = 1'b0;
  logic [DataWidth-1:0] expData    = '0;
  logic                 modelReady = 1'b0;

  // Update the model on each rising edge from the inputs the bench is driving.
  always @(posedge clk) begin
    if (!reset_n) begin
      modelQ.delete();
      prevDone   = 1'b1;
      modelOvr   = 1'b0;
      expValid   = 1'b0;
      expData    = '0;
      modelReady = 1'b1;
    end else begin
      bit rise;
      bit didRead;
      bit dropped;
      rise     = i_Rx_Done && !prevDone;
      prevDone = i_Rx_Done;
      didRead  = i_Rd_En && (modelQ.size() > 0);
      dropped  = 1'b0;
      expValid = 1'b0;
      if (didRead) begin
        expData  = modelQ.pop_front();
        expValid = 1'b1;
      end
      if (rise) begin
        if (modelQ.size() < Depth) modelQ.push_back(i_Rx_Byte);
        else dropped = 1'b1;
      end
      if (dropped) modelOvr = 1'b1;
      else if (i_Clr_Overrun) modelOvr = 1'b0;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("count",   32'(o_Count),    32'(modelQ.size()));
      checkOutput("empty",   32'(o_Empty),    32'(modelQ.size() == 0));
      checkOutput("full",    32'(o_Full),     32'(modelQ.size() == Depth));
      checkOutput("overrun", 32'(o_Overrun),  32'(modelOvr));
      checkOutput("rdValid", 32'(o_Rd_Valid), 32'(expValid));
      checkOutput("rdData",  32'(o_Rd_Data),  32'(expData));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // One done pulse: rising edge in the first cycle, low in the second.
  task automatic applyStimulus(input logic [DataWidth-1:0] b);
    i_Rx_Done = 1'b1;
    i_Rx_Byte = b;
    step();
    i_Rx_Done = 1'b0;
    step();
  endtask

  initial begin
    int pulses;
    logic [DataWidth-1:0] nextExp;
    logic [DataWidth-1:0] lastData;

    reset_n       = 1'b0;
    i_Rx_Done     = 1'b0;
    i_Rx_Byte     = '0;
    i_Rd_En       = 1'b0;
    i_Clr_Overrun = 1'b0;
    step();
    step();
    checkOutput("resetEmpty", 32'(o_Empty), 32'd1);
    checkOutput("resetCount", 32'(o_Count), 32'd0);
    reset_n = 1'b1;
    step();

    // Long done level gives exactly one entry.
    i_Rx_Done = 1'b1;
    i_Rx_Byte = 8'hA5;
    repeat (40) step();
    i_Rx_Done = 1'b0;
    step();
    checkOutput("longDoneCount", 32'(o_Count), 32'd1);
    checkOutput("longDoneEmpty", 32'(o_Empty), 32'd0);
    i_Rd_En = 1'b1;
    step();
    i_Rd_En = 1'b0;
    checkOutput("firstValid", 32'(o_Rd_Valid), 32'd1);
    checkOutput("firstData",  32'(o_Rd_Data),  32'hA5);
    step();
    checkOutput("singlePulse", 32'(o_Rd_Valid), 32'd0);
    checkOutput("emptyAfter",  32'(o_Empty),    32'd1);

    // Fill to full, then read 20 cycles.
    for (int i = 0; i < 16; i++) applyStimulus(8'(i));
    checkOutput("fillFull",  32'(o_Full),  32'd1);
    checkOutput("fillCount", 32'(o_Count), 32'd16);
    pulses  = 0;
    nextExp = 8'h00;
    i_Rd_En = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_Rd_Valid) begin
        checkOutput("orderData", 32'(o_Rd_Data), 32'(nextExp));
        nextExp++;
        pulses++;
      end
    end
    i_Rd_En = 1'b0;
    checkOutput("drainPulses", 32'(pulses), 32'd16);
    step();

    // Overrun: set, set-wins-over-clear, clear alone.
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h10 + i));
    applyStimulus(8'h77);
    checkOutput("overrunSet",   32'(o_Overrun), 32'd1);
    checkOutput("overrunCount", 32'(o_Count),   32'd16);
    i_Clr_Overrun = 1'b1;
    i_Rx_Done     = 1'b1;
    i_Rx_Byte     = 8'h78;
    step();
    i_Clr_Overrun = 1'b0;
    i_Rx_Done     = 1'b0;
    step();
    checkOutput("setWins", 32'(o_Overrun), 32'd1);
    i_Clr_Overrun = 1'b1;
    step();
    i_Clr_Overrun = 1'b0;
    checkOutput("clearAlone", 32'(o_Overrun), 32'd0);

    // Full FIFO: write 0x99 together with a read.
    i_Rx_Done = 1'b1;
    i_Rx_Byte = 8'h99;
    i_Rd_En   = 1'b1;
    step();
    i_Rx_Done = 1'b0;
    i_Rd_En   = 1'b0;
    checkOutput("fullRwHead",    32'(o_Rd_Data), 32'h10);
    checkOutput("fullRwCount",   32'(o_Count),   32'd16);
    checkOutput("fullRwOverrun", 32'(o_Overrun), 32'd0);
    step();
    lastData = '0;
    i_Rd_En  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (o_Rd_Valid) lastData = o_Rd_Data;
    end
    i_Rd_En = 1'b0;
    checkOutput("lastOut", 32'(lastData), 32'h99);
    step();

    // Wrap-around stream, occupancy held at 1..3 with interleaved reads.
    for (int i = 0; i < 40; i++) begin
      i_Rx_Done = 1'b1;
      i_Rx_Byte = 8'(8'h40 + i);
      i_Rd_En   = (i >= 3);
      step();
      i_Rx_Done = 1'b0;
      i_Rd_En   = 1'b0;
      step();
    end
    checkOutput("streamCount", 32'(o_Count), 32'd3);
    i_Rd_En = 1'b1;
    repeat (4) step();
    i_Rd_En = 1'b0;
    checkOutput("streamDrained", 32'(o_Empty), 32'd1);
    checkOutput("streamLast",    32'(o_Rd_Data), 32'h67);

    // Reset while done is held high; no capture on release.
    i_Rx_Done = 1'b1;
    i_Rx_Byte = 8'h55;
    step();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    checkOutput("relEmpty", 32'(o_Empty), 32'd1);
    checkOutput("relCount", 32'(o_Count), 32'd0);
    i_Rx_Done = 1'b0;
    step();
    applyStimulus(8'h66);
    checkOutput("postResetCount", 32'(o_Count), 32'd1);
    i_Rd_En = 1'b1;
    step();
    i_Rd_En = 1'b0;
    checkOutput("postResetData", 32'(o_Rd_Data), 32'h66);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
